// File: rtl/diffusion_decrypt.sv
// Pixel-diffusion decryption stage of the chaos-based image cipher.
// Inverts the encryption chaining C_i = P_i ^ K_i ^ C_{i-1}, where K_i is
// derived from the fractional bits of an IEEE-754 single keystream word.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                one-cycle pulse, begins a frame while idle
//   ks_valid_i/ks_data_i   keystream float, accepted with ks_ready_o
//   c_valid_i/c_data_i     ciphertext byte, accepted with c_ready_o
//   p_valid_o/p_data_o     plaintext byte, taken by downstream with p_ready_i
//   busy_o                 frame in progress (RUN or DRAIN)
//   done_o                 one-cycle pulse after the last pixel has left
module diffusion_decrypt #(
  parameter int unsigned PRECISION  = 32,
  parameter int unsigned IMG_PIXELS = 65536,
  parameter logic [7:0]  IV         = 8'h00
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 ks_valid_i,
  input  logic [PRECISION-1:0] ks_data_i,
  output logic                 ks_ready_o,
  input  logic                 c_valid_i,
  input  logic [7:0]           c_data_i,
  output logic                 c_ready_o,
  output logic                 p_valid_o,
  output logic [7:0]           p_data_o,
  input  logic                 p_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned     CntW    = $clog2(IMG_PIXELS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(IMG_PIXELS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [7:0]      prev_q, prev_d;
  logic [CntW-1:0] count_q, count_d;
  logic            p_valid_q, p_valid_d;
  logic [7:0]      p_data_q, p_data_d;
  logic            done_q, done_d;

  // Sign bit does not contribute to the key.
  logic unused_sign;
  assign unused_sign = ks_data_i[PRECISION-1];

  // Key extraction: F = floor(|x| * 2^24) mod 2^24, folded to a byte.
  logic [7:0]  exp_w;
  logic [23:0] mant;
  logic [7:0]  sh;
  logic [23:0] frac;
  logic [7:0]  key;

  always_comb begin
    exp_w = ks_data_i[30:23];
    mant  = {1'b1, ks_data_i[22:0]};
    sh    = 8'd0;
    frac  = 24'd0;
    if (exp_w == 8'd0 || exp_w == 8'hFF) begin
      frac = 24'd0;
    end else if (exp_w >= 8'd126) begin
      sh = exp_w - 8'd126;
      if (sh < 8'd24) frac = mant << sh;
    end else begin
      sh = 8'd126 - exp_w;
      if (sh < 8'd24) frac = mant >> sh;
    end
    key = frac[23:16] ^ frac[15:8] ^ frac[7:0];
  end

  // Join handshake: both streams move together, only when the output slot frees.
  logic out_free;
  logic in_ready;
  logic accept;

  assign out_free = !p_valid_q || p_ready_i;
  assign in_ready = (state_q == StRun) && out_free;
  assign accept   = in_ready && ks_valid_i && c_valid_i;

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    count_d   = count_q;
    p_valid_d = p_valid_q;
    p_data_d  = p_data_q;
    done_d    = 1'b0;

    if (accept) begin
      p_valid_d = 1'b1;
      p_data_d  = c_data_i ^ key ^ prev_q;
      prev_d    = c_data_i;
      count_d   = count_q + CntW'(1);
    end else if (p_ready_i) begin
      p_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          prev_d  = IV;
          count_d = '0;
        end
      end
      StRun: begin
        if (accept && count_q == LastCnt) state_d = StDrain;
      end
      StDrain: begin
        if (out_free) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      prev_q    <= IV;
      count_q   <= '0;
      p_valid_q <= 1'b0;
      p_data_q  <= 8'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      count_q   <= count_d;
      p_valid_q <= p_valid_d;
      p_data_q  <= p_data_d;
      done_q    <= done_d;
    end
  end

  assign ks_ready_o = in_ready;
  assign c_ready_o  = in_ready;
  assign p_valid_o  = p_valid_q;
  assign p_data_o   = p_data_q;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;

endmodule

// File: tb/tb_diffusion_decrypt.sv
// Self-checking bench for diffusion_decrypt with a 4-pixel frame.
// Expected plaintext is pushed to a queue when a pixel is accepted and
// popped when the output handshake happens.
module tb_diffusion_decrypt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ks_valid = 1'b0;
  logic [31:0] ks_data = 32'd0;
  logic        c_valid = 1'b0;
  logic [7:0]  c_data = 8'd0;
  logic        p_ready = 1'b0;
  logic        ks_ready_o;
  logic        c_ready_o;
  logic        p_valid_o;
  logic [7:0]  p_data_o;
  logic        busy_o;
  logic        done_o;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_prev = 8'h00;

  diffusion_decrypt #(
    .PRECISION (32),
    .IMG_PIXELS(4),
    .IV        (8'h00)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .ks_valid_i(ks_valid),
    .ks_data_i (ks_data),
    .ks_ready_o(ks_ready_o),
    .c_valid_i (c_valid),
    .c_data_i  (c_data),
    .c_ready_o (c_ready_o),
    .p_valid_o (p_valid_o),
    .p_data_o  (p_data_o),
    .p_ready_i (p_ready),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reference key via real arithmetic: floor(|x| * 2^24) mod 2^24, folded.
  function automatic logic [7:0] key_model(input logic [31:0] x);
    logic [7:0]  e;
    logic [63:0] db;
    real         r;
    int          f;
    logic [23:0] fb;
    e = x[30:23];
    if (e == 8'd0 || e == 8'hFF) return 8'h00;
    db = {1'b0, 11'(e) + 11'd896, x[22:0], 29'd0};
    r  = $bitstoreal(db) * 16777216.0;
    r  = r - $floor(r / 16777216.0) * 16777216.0;
    f  = $rtoi(r);
    fb = f[23:0];
    return fb[23:16] ^ fb[15:8] ^ fb[7:0];
  endfunction

  task automatic sb_push(input logic [31:0] kd, input logic [7:0] cd);
    exp_q.push_back(cd ^ key_model(kd) ^ m_prev);
    m_prev = cd;
  endtask

  function automatic logic [31:0] rand_ks();
    return {1'b0, 8'($urandom_range(100, 152)), 23'($urandom)};
  endfunction

  // Drive one cycle's inputs at the falling edge and report what the next
  // rising edge will do.
  task automatic drive_cycle(input logic st, input logic kv, input logic [31:0] kd,
                             input logic cv, input logic [7:0] cd, input logic pr,
                             output logic acc, output logic ohs, output logic [7:0] odat);
    @(negedge clk);
    start    = st;
    ks_valid = kv;
    ks_data  = kd;
    c_valid  = cv;
    c_data   = cd;
    p_ready  = pr;
    #1;
    acc  = kv && cv && ks_ready_o && c_ready_o;
    ohs  = p_valid_o && p_ready;
    odat = p_data_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (p_valid_o !== 1'b0) begin failures++; $display("FAIL reset_p_valid: got %b want 0", p_valid_o); end
    checks++; if (p_data_o !== 8'h00) begin failures++; $display("FAIL reset_p_data: got %h want 00", p_data_o); end
    checks++; if (ks_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ks_ready: got %b want 0", ks_ready_o); end
    checks++; if (c_ready_o !== 1'b0) begin failures++; $display("FAIL reset_c_ready: got %b want 0", c_ready_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done_o); end
    rst_n = 1'b1;
  endtask

  // Chaining vectors, latency, throughput, start-in-RUN ignored, frame end.
  task automatic test_chain_frame();
    logic [31:0] ks[4];
    logic [7:0]  cd[4];
    logic [7:0]  ce[4];
    logic        acc, ohs, bz_done;
    logic [7:0]  od, want;
    int idx = 0, n_acc = 0, n_ohs = 0, n_done = 0, done_cyc = -1, j;
    int first_acc = -1, last_acc = -1, first_ohs = -1, last_ohs = -1;
    bz_done = 1'b1;
    ks = '{32'h3f000000, 32'h3fe00000, 32'h3d4ccccd, 32'h40490fdb};
    cd = '{8'h55, 8'hAA, 8'h10, 8'h77};
    ce = '{8'hD5, 8'h3F, 8'hB6, 8'h00};
    drive_cycle(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b1, acc, ohs, od);
    m_prev = 8'h00;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      j = (idx > 3) ? 3 : idx;
      drive_cycle(cyc == 3, 1'b1, ks[j], 1'b1, cd[j], 1'b1, acc, ohs, od);
      if (cyc == 1) begin
        checks++;
        if (busy_o !== 1'b1) begin failures++; $display("FAIL busy_after_start: got %b want 1", busy_o); end
      end
      if (ohs) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL chain_out: got %h want none", od); end
        else begin
          want = exp_q.pop_front();
          if (od !== want) begin failures++; $display("FAIL chain_out: got %h want %h", od, want); end
        end
        n_ohs++;
        if (first_ohs < 0) first_ohs = cyc;
        last_ohs = cyc;
      end
      if (acc) begin
        if (idx < 3) begin exp_q.push_back(ce[idx]); m_prev = cd[idx]; end
        else if (idx == 3) sb_push(ks[3], cd[3]);
        idx++;
        n_acc++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (done_o) begin n_done++; done_cyc = cyc; bz_done = busy_o; end
    end
    checks++; if (n_acc != 4) begin failures++; $display("FAIL frame_accepts: got %0d want 4", n_acc); end
    checks++; if (n_ohs != 4) begin failures++; $display("FAIL frame_outputs: got %0d want 4", n_ohs); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL done_pulses: got %0d want 1", n_done); end
    checks++; if (done_cyc != last_ohs + 1) begin failures++; $display("FAIL done_timing: got %0d want %0d", done_cyc, last_ohs + 1); end
    checks++; if (bz_done !== 1'b0) begin failures++; $display("FAIL busy_at_done: got %b want 0", bz_done); end
    checks++; if (first_ohs - first_acc != 1) begin failures++; $display("FAIL latency: got %0d want 1", first_ohs - first_acc); end
    checks++; if (last_acc - first_acc != 3) begin failures++; $display("FAIL throughput: got %0d want 3", last_acc - first_acc); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL chain_leftover: got %0d want 0", exp_q.size()); end
  endtask

  // Degenerate exponents give K=00, each in a fresh frame.
  task automatic test_degenerate();
    logic [31:0] ks[4];
    logic [7:0]  cd[4];
    logic        acc, ohs;
    logic [7:0]  od, want;
    int idx, n_done, j;
    for (int f = 0; f < 3; f++) begin
      ks[0] = (f == 0) ? 32'h00000000 : (f == 1) ? 32'h7f800000 : 32'h4b800000;
      cd[0] = 8'h5A;
      for (int k = 1; k < 4; k++) begin ks[k] = rand_ks(); cd[k] = 8'($urandom); end
      idx = 0; n_done = 0;
      drive_cycle(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b1, acc, ohs, od);
      m_prev = 8'h00;
      for (int cyc = 1; cyc <= 10; cyc++) begin
        j = (idx > 3) ? 3 : idx;
        drive_cycle(1'b0, idx < 4, ks[j], idx < 4, cd[j], 1'b1, acc, ohs, od);
        if (ohs) begin
          checks++;
          if (exp_q.size() == 0) begin failures++; $display("FAIL degen_out: got %h want none", od); end
          else begin
            want = exp_q.pop_front();
            if (od !== want) begin failures++; $display("FAIL degen_out f%0d: got %h want %h", f, od, want); end
          end
        end
        if (acc) begin
          if (idx == 0) begin exp_q.push_back(8'h5A); m_prev = 8'h5A; end
          else sb_push(ks[j], cd[j]);
          idx++;
        end
        if (done_o) n_done++;
      end
      checks++; if (n_done != 1) begin failures++; $display("FAIL degen_done f%0d: got %0d want 1", f, n_done); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL degen_leftover f%0d: got %0d want 0", f, exp_q.size()); end
    end
  endtask

  // Lone keystream valid is never consumed; backpressure stalls both inputs.
  task automatic test_join_backpressure();
    logic [31:0] ks[4];
    logic [7:0]  cd[4];
    logic        acc, ohs, cv, pr;
    logic [7:0]  od, want, hold;
    int idx = 0, n_acc = 0, n_done = 0, rel_first = -1, rel_last = -1, j;
    hold = 8'h00;
    for (int k = 0; k < 4; k++) begin ks[k] = rand_ks(); cd[k] = 8'($urandom); end
    drive_cycle(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b1, acc, ohs, od);
    m_prev = 8'h00;
    for (int k = 0; k < 16; k++) begin
      j  = (idx > 3) ? 3 : idx;
      cv = (k >= 3);
      pr = !(k >= 4 && k <= 7);
      drive_cycle(1'b0, 1'b1, ks[j], cv, (k < 3) ? 8'hEE : cd[j], pr, acc, ohs, od);
      if (k < 3) begin
        checks++;
        if ({ks_ready_o, c_ready_o} !== 2'b11) begin
          failures++; $display("FAIL ready_lone_valid: got %b want 11", {ks_ready_o, c_ready_o});
        end
      end
      if (k == 4 && exp_q.size() > 0) hold = exp_q[0];
      if (k >= 4 && k <= 7) begin
        checks++;
        if ({ks_ready_o, c_ready_o, p_valid_o} !== 3'b001) begin
          failures++; $display("FAIL bp_readies k%0d: got %b want 001", k, {ks_ready_o, c_ready_o, p_valid_o});
        end
        checks++;
        if (p_data_o !== hold) begin failures++; $display("FAIL bp_hold k%0d: got %h want %h", k, p_data_o, hold); end
      end
      if (ohs) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL bp_out: got %h want none", od); end
        else begin
          want = exp_q.pop_front();
          if (od !== want) begin failures++; $display("FAIL bp_out: got %h want %h", od, want); end
        end
      end
      if (acc) begin
        if (idx < 4) sb_push(ks[j], cd[j]);
        idx++;
        n_acc++;
        if (k >= 8) begin
          if (rel_first < 0) rel_first = k;
          rel_last = k;
        end
      end
      if (done_o) n_done++;
    end
    checks++; if (n_acc != 4) begin failures++; $display("FAIL bp_accepts: got %0d want 4", n_acc); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL bp_done: got %0d want 1", n_done); end
    checks++; if (rel_last - rel_first != 2) begin failures++; $display("FAIL bp_resume_rate: got %0d want 2", rel_last - rel_first); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); end
  endtask

  // Mid-frame async reset aborts; the restarted frame chains from IV.
  task automatic test_async_reset();
    logic [31:0] ks[4];
    logic [7:0]  cd[4];
    logic        acc, ohs;
    logic [7:0]  od, want;
    int idx = 0, n_done = 0, j;
    drive_cycle(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b1, acc, ohs, od);
    m_prev = 8'h00;
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b0, 1'b1, rand_ks(), 1'b1, (k == 0) ? 8'h33 : 8'h44, 1'b1, acc, ohs, od);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({p_valid_o, ks_ready_o, c_ready_o, busy_o, done_o} !== 5'b0) begin
      failures++;
      $display("FAIL async_reset_ctrl: got %b want 00000", {p_valid_o, ks_ready_o, c_ready_o, busy_o, done_o});
    end
    checks++; if (p_data_o !== 8'h00) begin failures++; $display("FAIL async_reset_data: got %h want 00", p_data_o); end
    exp_q.delete();
    ks_valid = 1'b0;
    c_valid  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b0, 1'b1, 32'h3f000000, 1'b1, 8'h55, 1'b1, acc, ohs, od);
    checks++; if (ks_ready_o !== 1'b0) begin failures++; $display("FAIL no_start_ready: got %b want 0", ks_ready_o); end
    ks = '{32'h3f000000, rand_ks(), rand_ks(), rand_ks()};
    cd = '{8'h55, 8'($urandom), 8'($urandom), 8'($urandom)};
    drive_cycle(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b1, acc, ohs, od);
    m_prev = 8'h00;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      j = (idx > 3) ? 3 : idx;
      drive_cycle(1'b0, idx < 4, ks[j], idx < 4, cd[j], 1'b1, acc, ohs, od);
      if (ohs) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL restart_out: got %h want none", od); end
        else begin
          want = exp_q.pop_front();
          if (od !== want) begin failures++; $display("FAIL restart_out: got %h want %h", od, want); end
        end
      end
      if (acc) begin
        if (idx == 0) begin exp_q.push_back(8'hD5); m_prev = 8'h55; end
        else sb_push(ks[j], cd[j]);
        idx++;
      end
      if (done_o) n_done++;
    end
    checks++; if (n_done != 1) begin failures++; $display("FAIL restart_done: got %0d want 1", n_done); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL restart_leftover: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_chain_frame();
    test_degenerate();
    test_join_backpressure();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/diffusion_decrypt.md
# diffusion_decrypt

Pixel-diffusion decryption stage of the chaos-based image cipher. It consumes the IEEE-754 keystream produced by the `sawtooth` map engine and a stream of ciphertext bytes. It recovers plaintext pixels by inverting the encryption-side chaining `C_i = P_i ^ K_i ^ C_{i-1}`. It sits between the ciphertext source (DMA/UART) and the image sink, fed one keystream word per pixel.

## Interface
- `PRECISION`, 32: keystream float width; only 32 (single precision) is supported.
- `IMG_PIXELS`, 65536: pixels per image; the frame ends after this many accepted pixels.
- `IV`, 8'h00: chaining value used as `C_{-1}`.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle pulse; begins a frame when the block is IDLE.
- `ks_valid`  in  1  keystream word valid.
- `ks_data`  in  PRECISION  keystream float from `sawtooth`.
- `ks_ready`  out  1  keystream word accepted when both `ks_valid` and `ks_ready` are high.
- `c_valid`  in  1  ciphertext byte valid.
- `c_data`  in  8  ciphertext byte.
- `c_ready`  out  1  ciphertext accept.
- `p_valid`  out  1  plaintext byte valid.
- `p_data`  out  8  plaintext byte.
- `p_ready`  in  1  downstream accept.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when the frame completes.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on `start`. Entering RUN loads `prev` with `IV` and clears `count`.
  - RUN -> DRAIN when the pixel with `count == IMG_PIXELS-1` is accepted.
  - DRAIN -> IDLE when the output register is empty, or is emptied that cycle. `done` pulses for 1 cycle on that transition.
  - `start` is ignored outside IDLE.
- Join handshake: `ks_ready = c_ready = (state==RUN) && (!p_valid || p_ready)`.
  - A pixel is accepted only when `ks_valid && c_valid && ks_ready`.
  - Both streams are always consumed together. A lone valid on one stream is never consumed.
  - Ready does not depend on either input valid.
- Key extraction (combinational on `ks_data`). `E` = bits[30:23], `M` = {1, bits[22:0]} (24 bits). Sign is ignored.
  - `F = floor(|x| * 2^24) mod 2^24`.
  - E>=126: `F = (M << (E-126))[23:0]`. E<126: `F = M >> (126-E)`.
  - `E==0` gives F=0. Shifts of 24 or more give F=0, which covers E>=150 and E<=102.
  - E==255 (Inf/NaN) also gives F=0.
  - `K = F[23:16] ^ F[15:8] ^ F[7:0]`.
- On accept:
  - `p_data <= c_data ^ K ^ prev`, `p_valid <= 1`.
  - `prev <= c_data`, `count <= count+1`.
- Output register: `p_valid` clears on `p_ready` unless a new accept occurs in the same cycle. Simultaneous drain and accept keeps `p_valid` high with the new data.
- `p_data`/`p_valid` hold stable while `p_valid && !p_ready`.
- `count` width is `$clog2(IMG_PIXELS+1)`. It never wraps within a frame.

## Timing
- Reset values: `p_valid=0`, `p_data=0`, `ks_ready=0`, `c_ready=0`, `busy=0`, `done=0`, state IDLE, `prev=IV`, `count=0`.
- Latency: accept at edge N gives `p_valid` high after edge N, so data is visible in cycle N+1.
- Throughput: 1 pixel/cycle when all valids and `p_ready` are held high.
- `busy` goes high the cycle after `start` is sampled. It goes low in the same cycle `done` is high.
- Reset asserted mid-frame aborts immediately: all outputs take reset values and the partial frame is discarded. A new `start` is required.
- Backpressure: `p_ready=0` with `p_valid=1` drops both input readies in that same cycle.

## Test plan
- Single pixel, IV=00: `ks_data=3f000000` (0.5, K=80), `c_data=55` -> `p_data=D5` one cycle after accept.
- Chaining, continuing from the pixel above with prev=55: `ks_data=3fe00000` (1.75, F=C00000, K=C0), `c=AA` -> `p_data=3F`. Then `ks_data=3d4ccccd` (0.05, F=0CCCCC, K=0C), `c=10` -> `p_data=B6` (prev=AA).
- Degenerate keys: `ks_data` = 00000000, 7f800000, 4b800000 (E=151), each with IV=00 and `c_data=5A` (a fresh frame per case) -> K=00, `p_data=5A`.
- Join/backpressure:
  - `ks_valid` held 3 cycles with `c_valid=0` -> no accept, `count` unchanged.
  - `p_ready=0` for 4 cycles with `p_valid=1` -> readies low and `p_data` stable. Releasing it resumes at 1 pixel/cycle.
- Frame end, `IMG_PIXELS=4`, continuous streams:
  - `done` pulses once, 1 cycle after the 4th output handshake completes.
  - A further `c_valid` is not accepted.
  - `start` during RUN is ignored.
- Async reset after 2 of 4 pixels (`reset_n` low mid-cycle) -> outputs zero immediately. After restart with `start`, the first pixel decrypts with `prev=IV`.
